// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared state encoding and default geometry for the instruction loader
package instr_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } state_e;

   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;

endpackage

// File: rtl/instr_loader_prog_mem.sv
// prog_mem: DEPTH x 8 program store, synchronous write, combinational read
module prog_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // contents are intentionally not reset; the loader's length gates reachability
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_loader.sv
// instr_loader: loads a byte program from pins, then streams it to a CPU with stall support.
// Optional INSTR_LOADER_LOOP_EN: program repeats until LOAD_EN is raised, DONE never asserts.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic          LOAD_EN,
   input  logic [7:0]    DIN,
   input  logic          DIN_VALID,
   output logic          DIN_READY,
   input  logic          START,
   input  logic          STALL,
   output logic [7:0]    INSTRUCTION,
   output logic          WRITE_EN,
   output logic [AW-1:0] FETCH_ADDR,
   output logic          BUSY,
   output logic          DONE
);

   localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] ONE_A   = AW'(1);

   state_e        state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] fetch_q;
   logic [7:0]    instr_q;
   logic [7:0]    rdata;
   logic          wr_en;
   logic          issue;
   logic          last;

   prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk_i   (CLK),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (DIN),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   // outputs: a word is issued in any RUN cycle without STALL; otherwise the last issued word is held
   always_comb begin
      DIN_READY   = (state_q == LOAD) && (wr_ptr_q < DEPTH_W);
      wr_en       = DIN_VALID && DIN_READY;
      issue       = (state_q == RUN) && !STALL;
      last        = ({1'b0, rd_ptr_q} == (len_q - ONE_W));
      WRITE_EN    = issue;
      INSTRUCTION = issue ? rdata : instr_q;
      FETCH_ADDR  = issue ? rd_ptr_q : fetch_q;
      BUSY        = (state_q == LOAD) || (state_q == RUN);
      DONE        = (state_q == HALT);
   end

   // next-state and pointer updates
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      len_d    = len_q;
      rd_ptr_d = rd_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (LOAD_EN) begin
               state_d  = LOAD;
               wr_ptr_d = '0;
               len_d    = '0;
            end else if (START && (len_q != '0)) begin
               state_d  = RUN;
               rd_ptr_d = '0;
            end
         end
         LOAD: begin
            if (wr_en) begin
               wr_ptr_d = wr_ptr_q + ONE_W;
               len_d    = len_q + ONE_W;
            end
            if (!LOAD_EN) state_d = IDLE;
         end
         RUN: begin
            if (issue) begin
               rd_ptr_d = rd_ptr_q + ONE_A;
`ifdef INSTR_LOADER_LOOP_EN
               if (last) rd_ptr_d = '0;
`else
               if (last) state_d = HALT;
`endif
            end
`ifdef INSTR_LOADER_LOOP_EN
            if (LOAD_EN) state_d = IDLE;
`endif
         end
         HALT: begin
            if (LOAD_EN || START) state_d = IDLE;
         end
      endcase
   end

   // state register with synchronous active-low reset; output hold registers track what was shown
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         len_q    <= '0;
         rd_ptr_q <= '0;
         fetch_q  <= '0;
         instr_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         len_q    <= len_d;
         rd_ptr_q <= rd_ptr_d;
         fetch_q  <= FETCH_ADDR;
         instr_q  <= INSTRUCTION;
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench; issued words are checked against an expected queue
module tb_instr_loader;

   logic       CLK = 1'b0;
   logic       RESET_N, LOAD_EN, DIN_VALID, START, STALL;
   logic [7:0] DIN;
   logic       DIN_READY, WRITE_EN, BUSY, DONE;
   logic [7:0] INSTRUCTION;
   logic [3:0] FETCH_ADDR;

   typedef struct {
      logic [7:0] d;
      logic [3:0] a;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] prog [32];
   int         tests = 0;
   int         fails = 0;

   instr_loader #(.DEPTH(16), .AW(4)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .LOAD_EN     (LOAD_EN),
      .DIN         (DIN),
      .DIN_VALID   (DIN_VALID),
      .DIN_READY   (DIN_READY),
      .START       (START),
      .STALL       (STALL),
      .INSTRUCTION (INSTRUCTION),
      .WRITE_EN    (WRITE_EN),
      .FETCH_ADDR  (FETCH_ADDR),
      .BUSY        (BUSY),
      .DONE        (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every issued word must match the head of the expected queue
   always @(negedge CLK) begin
      if (WRITE_EN === 1'b1) begin
         if (exp_q.size() == 0) check("spurious_write_en", WRITE_EN, 0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            check("instruction", INSTRUCTION, e.d);
            check("fetch_addr", FETCH_ADDR, e.a);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input int n);
      int k = 0;
      LOAD_EN = 1'b1;
      do begin
         tick();
         k++;
      end while (!BUSY && k < 4);
      check("enter_load_busy", BUSY, 1);
      for (int i = 0; i < n; i++) begin
         DIN       = prog[i];
         DIN_VALID = 1'b1;
         #1;
         check("din_ready", DIN_READY, (i < 16) ? 1 : 0);
         tick();
      end
      DIN_VALID = 1'b0;
      LOAD_EN   = 1'b0;
      tick();
      check("load_exit_busy", BUSY, 0);
   endtask

   task automatic push_exp(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.d = prog[i % 32];
         e.a = 4'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done();
      int k = 0;
      while (!DONE && k < 60) begin
         tick();
         k++;
      end
      check("done_reached", DONE, 1);
      check("scoreboard_empty", exp_q.size(), 0);
      START = 1'b1;
      tick();
      START = 1'b0;
      check("halt_to_idle_done", DONE, 0);
      check("halt_to_idle_busy", BUSY, 0);
   endtask

   task automatic start_pulse();
      START = 1'b1;
      tick();
      START = 1'b0;
      check("start_latency_we", WRITE_EN, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RESET_N = 1'b0; LOAD_EN = 1'b0; DIN = 8'h00; DIN_VALID = 1'b0; START = 1'b0; STALL = 1'b0;
      tick();
      tick();
      RESET_N = 1'b1;
      check("rst_instruction", INSTRUCTION, 8'h00);
      check("rst_fetch_addr", FETCH_ADDR, 0);
      check("rst_write_en", WRITE_EN, 0);
      check("rst_din_ready", DIN_READY, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);

      // START with nothing loaded is ignored
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("empty_start_busy", BUSY, 0);
         check("empty_start_we", WRITE_EN, 0);
         tick();
      end

`ifdef INSTR_LOADER_LOOP_EN
      prog[0] = 8'h05; prog[1] = 8'h06;
      load(2);
      for (int i = 0; i < 6; i++) begin
         exp_t e;
         e.d = prog[i % 2];
         e.a = 4'(i % 2);
         exp_q.push_back(e);
      end
      start_pulse();
      for (int i = 0; i < 5; i++) begin
         check("loop_done_low", DONE, 0);
         tick();
      end
      LOAD_EN = 1'b1;
      tick();
      check("loop_exit_we", WRITE_EN, 0);
      check("loop_exit_done", DONE, 0);
      check("loop_scoreboard_empty", exp_q.size(), 0);
      LOAD_EN = 1'b0;
      tick();
      tick();
`else
      // basic three-word program
      prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h04;
      load(3);
      push_exp(3);
      start_pulse();
      wait_done();

      // same program with a two-cycle stall after the first issue
      load(3);
      push_exp(3);
      start_pulse();
      tick();
      STALL = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("stall_we", WRITE_EN, 0);
         check("stall_hold_instr", INSTRUCTION, 8'h01);
         check("stall_hold_addr", FETCH_ADDR, 0);
         tick();
      end
      STALL = 1'b0;
      wait_done();

      // overfill: 18 bytes offered, only 16 stored and issued
      for (int i = 0; i < 18; i++) prog[i] = 8'(8'h10 + i);
      load(18);
      push_exp(16);
      start_pulse();
      wait_done();

      // reset while the second word is on the bus
      prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h04;
      load(3);
      push_exp(2);
      start_pulse();
      tick();
      check("second_word_we", WRITE_EN, 1);
      RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      check("abort_instruction", INSTRUCTION, 8'h00);
      check("abort_fetch_addr", FETCH_ADDR, 0);
      check("abort_write_en", WRITE_EN, 0);
      check("abort_din_ready", DIN_READY, 0);
      check("abort_busy", BUSY, 0);
      check("abort_done", DONE, 0);
      check("abort_scoreboard_empty", exp_q.size(), 0);
      START = 1'b1;
      tick();
      START = 1'b0;
      check("abort_len_cleared", BUSY, 0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
